game_scoreboard: RTL and testbench

GAME_SCOREBOARD -- requirements
Module: game_scoreboard

---
 rtl/game_scoreboard.sv | 184 ++++++++++++++++++
 tb/tb_game_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_scoreboard.sv
// Game timer and per-player score keeper driven by a video frame strobe.
// Optional BCD timer output: define GAME_SCOREBOARD_BCD_EN.
module game_scoreboard #(
    parameter int NUM_PLAYERS    = 2,
    parameter int SCORE_W        = 7,
    parameter int TIMER_W        = 5,
    parameter int GAME_SECONDS   = 30,
    parameter int FRAMES_PER_SEC = 60,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_in,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           shot_valid,
    input  logic [PW-1:0]                  shot_player,
    input  logic [1:0]                     shot_points,
    output logic [TIMER_W-1:0]             timer,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                     state,
    output logic                           game_over,
    output logic [7:0]                     timer_bcd
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0]      FC_MAX = FW'(FRAMES_PER_SEC - 1);
    localparam logic [TIMER_W-1:0] T_LOAD = TIMER_W'(GAME_SECONDS);
    localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t                         state_q, state_d;
    logic [TIMER_W-1:0]             timer_q, timer_d;
    logic [FW-1:0]                  fcnt_q, fcnt_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic                           game_over_q;
    logic                           sync1, sync2, sync3;
    logic                           frame_tick;
    logic                           sec_tick;
    logic                           load;
    logic                           dec;

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [1:0]         b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {{(SCORE_W-1){1'b0}}, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    // Synchronize frame_in and emit a one-cycle pulse on its rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= frame_in;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= sync2 & ~sync3;
        end
    end

    // Frame counter advances only while running; wrap marks one second.
    always_comb begin
        fcnt_d   = fcnt_q;
        sec_tick = 1'b0;
        if (state_q == S_RUN && frame_tick) begin
            if (fcnt_q == FC_MAX) begin
                fcnt_d   = '0;
                sec_tick = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Game FSM next state, timer and score updates; start overrides all.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        scores_d = scores_q;
        load     = 1'b0;
        dec      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) load = 1'b1;
            end
            S_RUN: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (shot_valid && shot_player == PW'(i)) begin
                            scores_d[i*SCORE_W +: SCORE_W] =
                                sat_add(scores_q[i*SCORE_W +: SCORE_W],
                                        shot_points);
                        end
                    end
                    if (sec_tick) dec = 1'b1;
                    if (sec_tick && timer_q == T_ONE) begin
                        state_d = S_OVER;
                    end else if (pause) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (start) begin
                    load = 1'b1;
                end else if (pause) begin
                    state_d = S_RUN;
                end
            end
            S_OVER: begin
                if (start) load = 1'b1;
            end
        endcase
        if (dec) timer_d = timer_q - T_ONE;
        if (load) begin
            state_d  = S_RUN;
            timer_d  = T_LOAD;
            scores_d = '0;
        end
    end

    // State, timer, frame counter and score registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            fcnt_q      <= '0;
            scores_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fcnt_q      <= load ? '0 : fcnt_d;
            scores_q    <= scores_d;
            game_over_q <= (state_d == S_OVER);
        end
    end

`ifdef GAME_SCOREBOARD_BCD_EN
    localparam logic [7:0] BCD_LOAD =
        {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

    logic [7:0] bcd_q;

    // Two-digit BCD copy of the timer, loaded and decremented with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
        end else if (load) begin
            bcd_q <= BCD_LOAD;
        end else if (dec) begin
            if (bcd_q[3:0] == 4'd0) begin
                bcd_q <= {bcd_q[7:4] - 4'd1, 4'd9};
            end else begin
                bcd_q[3:0] <= bcd_q[3:0] - 4'd1;
            end
        end
    end

    assign timer_bcd = bcd_q;
`else
    assign timer_bcd = 8'h00;
`endif

    assign timer     = timer_q;
    assign scores    = scores_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_scoreboard.sv
// Bench for game_scoreboard: behavioural model plus directed scenarios.
// Random phase exercises start/pause/shot/frame/reset interleavings.
module tb_game_scoreboard;

    localparam int NP  = 2;
    localparam int SW  = 7;
    localparam int TW  = 5;
    localparam int GS  = 30;
    localparam int FPS = 60;
    localparam int MAXS = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_in = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          shot_valid = 1'b0;
    logic [0:0]    shot_player = 1'b0;
    logic [1:0]    shot_points = 2'd0;
    logic [TW-1:0] timer;
    logic [NP*SW-1:0] scores;
    logic [1:0]    state;
    logic          game_over;
    logic [7:0]    timer_bcd;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // model: state 0 idle, 1 run, 2 pause, 3 over
    int m_state;
    int m_timer;
    int m_frames;
    int m_score[NP];
    bit fh[4];

    game_scoreboard #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .TIMER_W(TW),
        .GAME_SECONDS(GS), .FRAMES_PER_SEC(FPS)
    ) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in),
        .start(start), .pause(pause), .shot_valid(shot_valid),
        .shot_player(shot_player), .shot_points(shot_points),
        .timer(timer), .scores(scores), .state(state),
        .game_over(game_over), .timer_bcd(timer_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NP*SW-1:0] exp_scores();
        logic [NP*SW-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[i*SW +: SW] = SW'(m_score[i]);
        return v;
    endfunction

    function automatic logic [7:0] exp_bcd();
`ifdef GAME_SCOREBOARD_BCD_EN
        return 8'(((m_timer / 10) << 4) | (m_timer % 10));
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] lit_bcd(input logic [7:0] v);
`ifdef GAME_SCOREBOARD_BCD_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic m_clear();
        m_state = 0;
        m_timer = 0;
        m_frames = 0;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        for (int i = 0; i < 4; i++) fh[i] = 1'b0;
    endtask

    // A frame rise seen at edge n produces its effect at edge n+3.
    task automatic m_step();
        bit tick;
        tick = fh[2] && !fh[3];
        fh[3] = fh[2];
        fh[2] = fh[1];
        fh[1] = fh[0];
        fh[0] = frame_in;
        if (start) begin
            m_state = 1;
            m_timer = GS;
            m_frames = 0;
            for (int i = 0; i < NP; i++) m_score[i] = 0;
        end else if (m_state == 1) begin
            if (shot_valid && int'(shot_player) < NP) begin
                m_score[shot_player] += int'(shot_points);
                if (m_score[shot_player] > MAXS) m_score[shot_player] = MAXS;
            end
            if (tick) begin
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0;
                    m_timer--;
                    if (m_timer == 0) m_state = 3;
                end
            end
            if (m_state == 1 && pause) m_state = 2;
        end else if (m_state == 2 && pause) begin
            m_state = 1;
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_clear();
            else m_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("timer", 32'(timer), 32'(m_timer));
            check("scores", 32'(scores), 32'(exp_scores()));
            check("state", 32'(state), 32'(m_state));
            check("game_over", 32'(game_over), 32'(m_state == 3));
            check("timer_bcd", 32'(timer_bcd), 32'(exp_bcd()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
    endtask

    task automatic frame_rises(input int n);
        for (int i = 0; i < n; i++) begin
            frame_in = 1'b1;
            cyc(2);
            frame_in = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        cyc(2);
        cmp_en = 1'b1;
        reset = 1'b0;
        cyc(1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_timer", 32'(timer), 32'd0);
        check("rst_bcd", 32'(timer_bcd), 32'd0);

        // one second, then the full game
        pulse_start();
        check("load_timer", 32'(timer), 32'd30);
        frame_rises(60);
        check("sec1_timer", 32'(timer), 32'd29);
        frame_rises(1740);
        check("end_timer", 32'(timer), 32'd0);
        check("end_state", 32'(state), 32'd3);
        check("end_over", 32'(game_over), 32'd1);

        // shot in the expiry cycle is counted, later one is not
        pulse_start();
        frame_rises(1799);
        check("last_sec", 32'(timer), 32'd1);
        frame_in = 1'b1;
        cyc(2);
        frame_in = 1'b0;
        cyc(1);
        shot_valid = 1'b1;
        shot_player = 1'b0;
        shot_points = 2'd2;
        cyc(1);
        shot_valid = 1'b0;
        check("exp_state", 32'(state), 32'd3);
        check("exp_score", 32'(scores[SW-1:0]), 32'd2);
        shot_valid = 1'b1;
        cyc(1);
        shot_valid = 1'b0;
        check("over_shot", 32'(scores[SW-1:0]), 32'd2);
        pulse_pause();
        check("over_pause", 32'(state), 32'd3);
        pulse_start();
        check("restart_t", 32'(timer), 32'd30);
        check("restart_s", 32'(scores), 32'd0);

        // saturation
        shot_player = 1'b1;
        shot_points = 2'd3;
        for (int i = 0; i < 43; i++) begin
            shot_valid = 1'b1;
            cyc(1);
        end
        shot_valid = 1'b0;
        check("sat_p1", 32'(scores[2*SW-1:SW]), 32'd127);
        check("sat_p0", 32'(scores[SW-1:0]), 32'd0);

        // pause holds frame count and timer
        pulse_start();
        frame_rises(30);
        pulse_pause();
        check("paused", 32'(state), 32'd2);
        frame_rises(120);
        check("pause_hold", 32'(timer), 32'd30);
        pulse_pause();
        check("resumed", 32'(state), 32'd1);
        frame_rises(29);
        check("resume_59", 32'(timer), 32'd30);
        frame_rises(1);
        check("resume_60", 32'(timer), 32'd29);

        // BCD tracking
        frame_rises(600);
        check("t19", 32'(timer), 32'd19);
        check("bcd19", 32'(timer_bcd), 32'(lit_bcd(8'h19)));
        frame_rises(60);
        check("bcd18", 32'(timer_bcd), 32'(lit_bcd(8'h18)));

        // start beats pause; reset aborts mid-game
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        start = 1'b1;
        pause = 1'b1;
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        check("start_wins", 32'(state), 32'd1);
        frame_in = 1'b1;
        shot_valid = 1'b1;
        shot_points = 2'd3;
        cyc(1);
        reset = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_score", 32'(scores), 32'd0);
        check("arst_timer", 32'(timer), 32'd0);
        check("arst_over", 32'(game_over), 32'd0);
        cyc(2);
        reset = 1'b0;
        shot_valid = 1'b0;
        cyc(5);
        frame_in = 1'b0;
        check("post_state", 32'(state), 32'd0);
        check("post_score", 32'(scores), 32'd0);

        // randomized interleavings
        pulse_start();
        for (int c = 0; c < 6000; c++) begin
            start = ($urandom_range(0, 799) == 0);
            pause = ($urandom_range(0, 39) == 0);
            shot_valid = ($urandom_range(0, 2) == 0);
            shot_player = 1'($urandom_range(0, 1));
            shot_points = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) frame_in = ~frame_in;
            reset = ($urandom_range(0, 2999) == 0);
            cyc(1);
        end
        start = 1'b0;
        pause = 1'b0;
        shot_valid = 1'b0;
        reset = 1'b0;
        cyc(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
